// File: rtl/img_downsample.sv
// Streams a raster SRC_DIM x SRC_DIM grayscale frame into a 7x7 binary image (block sum >= threshold).
// Build option: IMG_DS_INVERT_EN inverts each pixel before accumulation (dark ink -> 1 bits).

module img_ds_lane #(
  parameter int PIX_W      = 8,
  parameter int ACC_W      = 12,
  parameter int SUM_THRESH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             commit,
  input  logic             sel,
  input  logic [PIX_W-1:0] px,
  output logic             hit
);
  localparam logic [ACC_W:0] THR = (ACC_W+1)'(SUM_THRESH);

  logic [ACC_W-1:0] acc_q, acc_d, sum;

  always_comb begin
    sum   = (clr ? '0 : acc_q) + (sel ? ACC_W'(px) : '0);
    hit   = ({1'b0, sum} >= THR);
    acc_d = acc_q;
    if (en) acc_d = commit ? '0 : sum;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
endmodule

module img_downsample #(
  parameter int PIX_W      = 8,
  parameter int SRC_DIM    = 28,
  parameter int BLK        = 4,
  parameter int SUM_THRESH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             sof,
  output logic [48:0]      img,
  output logic             img_valid,
  output logic             frame_abort
);
  localparam int NB    = 7;
  localparam int CNT_W = $clog2(SRC_DIM);
  localparam int BLK_W = $clog2(BLK);
  localparam int ACC_W = PIX_W + 2*BLK_W;
  localparam int BI_W  = $clog2(NB);

  logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
  logic [48:0]      work_q, work_d, img_q, img_d;
  logic             img_valid_q, img_valid_d, frame_abort_q, frame_abort_d;

  logic [CNT_W-1:0] eff_row, eff_col;
  logic [BI_W-1:0]  blk_col, band;
  logic             abort, band_end, last;
  logic [PIX_W-1:0] px;
  logic [NB-1:0]    hit;

  // sof always forces the current pixel to (0,0); anywhere else it also discards the partial frame
  always_comb begin
    eff_row  = sof ? '0 : row_q;
    eff_col  = sof ? '0 : col_q;
    abort    = pix_valid && sof && (row_q != '0 || col_q != '0);
    blk_col  = BI_W'(eff_col / CNT_W'(BLK));
    band     = BI_W'(eff_row / CNT_W'(BLK));
    band_end = (eff_row % CNT_W'(BLK) == CNT_W'(BLK-1)) && (eff_col == CNT_W'(SRC_DIM-1));
    last     = band_end && (eff_row == CNT_W'(SRC_DIM-1));
`ifdef IMG_DS_INVERT_EN
    px = ~pix_data;
`else
    px = pix_data;
`endif
  end

  for (genvar g = 0; g < NB; g++) begin : g_lane
    img_ds_lane #(
      .PIX_W     (PIX_W),
      .ACC_W     (ACC_W),
      .SUM_THRESH(SUM_THRESH)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (pix_valid),
      .clr   (abort),
      .commit(band_end),
      .sel   (blk_col == BI_W'(g)),
      .px    (px),
      .hit   (hit[g])
    );
  end

  always_comb begin
    row_d         = row_q;
    col_d         = col_q;
    work_d        = work_q;
    img_d         = img_q;
    img_valid_d   = 1'b0;
    frame_abort_d = abort;
    if (pix_valid) begin
      if (abort) work_d = '0;
      if (band_end) begin
        for (int c = 0; c < NB; c++) work_d[int'(band)*NB + c] = hit[c];
      end
      if (last) begin
        img_d       = work_d;
        img_valid_d = 1'b1;
      end
      if (eff_col == CNT_W'(SRC_DIM-1)) begin
        col_d = '0;
        row_d = last ? '0 : eff_row + 1'b1;
      end else begin
        col_d = eff_col + 1'b1;
        row_d = eff_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q         <= '0;
      col_q         <= '0;
      work_q        <= '0;
      img_q         <= '0;
      img_valid_q   <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      row_q         <= row_d;
      col_q         <= col_d;
      work_q        <= work_d;
      img_q         <= img_d;
      img_valid_q   <= img_valid_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign img         = img_q;
  assign img_valid   = img_valid_q;
  assign frame_abort = frame_abort_q;
endmodule

// File: tb/tb_img_downsample.sv
// Scoreboard bench for img_downsample: stimulus pushes expected images, a monitor checks each img_valid.
module tb_img_downsample;
  logic        clk = 1'b0;
  logic        reset, pix_valid, sof;
  logic [7:0]  pix_data;
  logic [48:0] img;
  logic        img_valid, frame_abort;

  img_downsample dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data), .sof(sof),
    .img(img), .img_valid(img_valid), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  typedef struct { logic [48:0] img; int due; } exp_t;
  exp_t sb[$];
  int   vtimes[$];
  int   cyc = 0, total = 0, bad = 0, vcnt = 0, acnt = 0;
  localparam logic [48:0] ALL1 = {49{1'b1}};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!reset && frame_abort) acnt++;
    if (img_valid) begin
      vcnt++;
      vtimes.push_back(cyc);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_img_valid img=%h cyc=%0d", img, cyc);
      end else begin
        e = sb.pop_front();
        if (img !== e.img || cyc != e.due) begin
          bad++;
          $display("FAIL img_frame got img=%h cyc=%0d want img=%h cyc=%0d", img, cyc, e.img, e.due);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] drv(input logic [7:0] p);
`ifdef IMG_DS_INVERT_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  function automatic logic [7:0] pix_at(input int kind, v, br, bc, seed, r, c);
    case (kind)
      0:       return 8'(v);
      1:       return (r/4 == br && c/4 == bc) ? 8'hFF : 8'h00;
      default: return ((r/4*7 + c/4 + seed) % 3 == 0) ? 8'((r*37 + c*11 + seed) % 256)
                                                      : 8'((r + c + seed) % 40);
    endcase
  endfunction

  function automatic logic [48:0] model(input int kind, v, br, bc, seed);
    logic [48:0] m;
    int s;
    m = '0;
    for (int a = 0; a < 7; a++)
      for (int b = 0; b < 7; b++) begin
        s = 0;
        for (int r = a*4; r < a*4+4; r++)
          for (int c = b*4; c < b*4+4; c++) s += int'(pix_at(kind, v, br, bc, seed, r, c));
        m[a*7+b] = (s >= 1024);
      end
    return m;
  endfunction

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic send_px(input logic [7:0] p, input logic s);
    pix_valid = 1'b1; pix_data = drv(p); sof = s;
    @(posedge clk); #1;
    pix_valid = 1'b0; pix_data = '0; sof = 1'b0;
  endtask

  task automatic run_px(input int kind, v, br, bc, seed, lo, hi, input bit sof_first,
                        input int gap_pct, input bit push_en, input logic [48:0] expv);
    for (int i = lo; i <= hi; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) repeat ($urandom_range(1, 3)) idle();
      send_px(pix_at(kind, v, br, bc, seed, i/28, i%28), sof_first && i == lo);
    end
    if (push_en && hi == 783) sb.push_back('{expv, cyc});
  endtask

  initial begin
    int n0, vb;
    reset = 1'b1; pix_valid = 1'b0; sof = 1'b0; pix_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_img", 64'(img), 64'h0);
    chk("reset_img_valid", 64'(img_valid), 64'h0);
    chk("reset_frame_abort", 64'(frame_abort), 64'h0);
    reset = 1'b0;
    idle();

    // all dark, then threshold boundary either side
    run_px(0, 0, 0, 0, 0, 0, 783, 1, 0, 1, 49'h0);
    run_px(0, 64, 0, 0, 0, 0, 783, 0, 0, 1, ALL1);
    run_px(0, 63, 0, 0, 0, 0, 783, 0, 0, 1, 49'h0);

    // single bright blocks at centre and corners
    run_px(1, 0, 3, 3, 0, 0, 783, 0, 0, 1, 49'h1 << 24);
    run_px(1, 0, 0, 6, 0, 0, 783, 0, 0, 1, 49'h1 << 6);
    run_px(1, 0, 6, 0, 0, 0, 783, 0, 0, 1, 49'h1 << 42);

    // partial frame discarded by sof
    run_px(0, 255, 0, 0, 0, 0, 783, 0, 0, 1, ALL1);
    run_px(0, 0, 0, 0, 0, 0, 299, 0, 0, 0, '0);
    send_px(8'h00, 1'b1);
    @(negedge clk);
    chk("abort_pulse", 64'(frame_abort), 64'h1);
    chk("abort_img_hold", 64'(img), 64'(ALL1));
    run_px(0, 0, 0, 0, 0, 1, 783, 0, 0, 1, 49'h0);

    // back-to-back gapless frames, then the same frames with random gaps
    repeat (2) idle();
    n0 = vtimes.size();
    run_px(2, 0, 0, 0, 1, 0, 783, 0, 0, 1, model(2, 0, 0, 0, 1));
    run_px(2, 0, 0, 0, 2, 0, 783, 0, 0, 1, model(2, 0, 0, 0, 2));
    @(negedge clk); #1;
    chk("b2b_count", 64'(vtimes.size() - n0), 64'd2);
    if (vtimes.size() >= n0 + 2)
      chk("b2b_spacing", 64'(vtimes[n0+1] - vtimes[n0]), 64'd784);
    run_px(2, 0, 0, 0, 1, 0, 783, 0, 30, 1, model(2, 0, 0, 0, 1));
    run_px(2, 0, 0, 0, 2, 0, 783, 0, 30, 1, model(2, 0, 0, 0, 2));

    // reset in the middle of a frame
    repeat (2) idle();
    vb = vcnt;
    run_px(2, 0, 0, 0, 3, 0, 499, 0, 0, 0, '0);
    reset = 1'b1;
    idle();
    chk("midreset_img", 64'(img), 64'h0);
    chk("midreset_img_valid", 64'(img_valid), 64'h0);
    chk("midreset_frame_abort", 64'(frame_abort), 64'h0);
    reset = 1'b0;
    run_px(2, 0, 0, 0, 4, 0, 783, 1, 0, 1, model(2, 0, 0, 0, 4));
    repeat (4) idle();
    chk("midreset_valid_count", 64'(vcnt - vb), 64'd1);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("abort_total", 64'(acnt), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
